fetch_queue: RTL and testbench

Instruction fetch queue sitting directly downstream of the IF stage and upstream of ID. Each cycle it captures the PC presented by IF together with the instruction-memory word at that PC. It buffers up to DEPTH {pc, instr} entries in a ring buffer and presents the oldest entry to ID with a valid/ready handshake. It drives IF's stall input when it cannot accept, and discards all wrong-path entries on a taken branch or jump.

---
 rtl/fetch_queue_pkg.sv | 37 +++
 rtl/fetch_queue_ring.sv | 60 ++++++
 rtl/fetch_queue.sv | 82 ++++++++
 tb/tb_fetch_queue.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue: widths, PC and
// instruction types, the NOP word and grouped port bundles.
package fetch_queue_pkg;

  localparam int PC_W     = 32;
  localparam int INSTR_W  = 32;
  localparam int FQ_DEPTH = 4;
  localparam int FQ_CNT_W = $clog2(FQ_DEPTH + 1);

  typedef logic [PC_W-1:0]    ProgramCounter;
  typedef logic [INSTR_W-1:0] Instruction;

  // All-zero word presented to ID whenever the queue is empty.
  localparam Instruction NOP = {INSTR_W{1'b0}};

  typedef struct packed {
    ProgramCounter if_pc;
    Instruction    imem_instr;
    logic          flush;
    logic          id_ready;
  } FQ_input;

  typedef struct packed {
    logic                id_valid;
    ProgramCounter       id_pc;
    Instruction          id_instr;
    logic                stall;
    logic [FQ_CNT_W-1:0] count;
  } FQ_output;

  // Advance a ring pointer that carries one extra wrap bit.
  function automatic logic [$clog2(FQ_DEPTH):0] fq_ptr_inc(
      input logic [$clog2(FQ_DEPTH):0] ptr);
    return ptr + {{$clog2(FQ_DEPTH){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/fetch_queue_ring.sv
// Ring buffer behind the fetch queue: storage array, read/write pointers
// with an extra wrap bit, and occupancy derived from the pointer distance.
module fq_ring #(
  parameter int DEPTH = 4,
  parameter int W     = 64,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count
);

  logic [W-1:0] mem_r [DEPTH];
  logic [AW:0]  wr_ptr_r;
  logic [AW:0]  rd_ptr_r;
  logic [AW:0]  dist_s;

  // Pointer movement; clear collapses both pointers so the queue reads empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else if (clear) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // Entry storage, written at the low bits of the write pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {W{1'b0}};
      end
    end else if (push && !clear) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wdata;
    end
  end

  // Occupancy: the wrap bit makes full (distance DEPTH) differ from empty (0).
  always_comb begin
    dist_s = wr_ptr_r - rd_ptr_r;
    count  = CW'(dist_s);
    rdata  = mem_r[rd_ptr_r[AW-1:0]];
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue between IF and ID: captures {pc, instr} every
// cycle, presents the oldest entry to ID, stalls IF when full and drops
// all wrong-path entries on a taken branch or jump.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int INSTR_W = 32,
  parameter int PC_W    = fetch_queue_pkg::PC_W,
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PC_W-1:0]    if_pc,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               flush,
  input  logic               id_ready,
  output logic               id_valid,
  output logic [PC_W-1:0]    id_pc,
  output logic [INSTR_W-1:0] id_instr,
  output logic               stall,
  output logic [CW-1:0]      count
);

  localparam int            EW      = PC_W + INSTR_W;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic          push_s;
  logic          pop_s;
  logic          full_s;
  logic          valid_s;
  logic          stall_s;
  logic [CW-1:0] count_s;
  logic [EW-1:0] rdata_s;
  logic [EW-1:0] wdata_s;

  assign wdata_s = {if_pc, imem_instr};

  fq_ring #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_ring (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .clear (flush),
    .wdata (wdata_s),
    .rdata (rdata_s),
    .count (count_s)
  );

  // Handshake and stall: a pop frees a slot in the same cycle, and a flush
  // never stalls so the redirect in IF is not suppressed.
  always_comb begin
    valid_s = (count_s != {CW{1'b0}});
    full_s  = (count_s == DEPTH_C);
    pop_s   = valid_s & id_ready;
    if (flush) begin
      push_s  = 1'b0;
      stall_s = 1'b0;
    end else begin
      push_s  = ~full_s | pop_s;
      stall_s = full_s & ~pop_s;
    end
  end

  // ID-side outputs: head entry when valid, otherwise NOP at PC 0.
  always_comb begin
    id_valid = valid_s;
    stall    = stall_s;
    count    = count_s;
    if (valid_s) begin
      id_pc    = rdata_s[INSTR_W +: PC_W];
      id_instr = rdata_s[INSTR_W-1:0];
    end else begin
      id_pc    = {PC_W{1'b0}};
      id_instr = INSTR_W'(NOP);
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: an IF model drives PCs, a queue
// based reference model predicts every output each cycle.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int IW    = 32;
  localparam int PW    = fetch_queue_pkg::PC_W;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          reset;
  logic [PW-1:0] if_pc;
  logic [IW-1:0] imem_instr;
  logic          flush;
  logic          id_ready;
  logic          id_valid;
  logic [PW-1:0] id_pc;
  logic [IW-1:0] id_instr;
  logic          stall;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;

  logic [PW-1:0] mq_pc[$];
  logic [IW-1:0] mq_in[$];
  logic [PW-1:0] pc_m;

  fetch_queue #(.DEPTH(DEPTH), .INSTR_W(IW), .PC_W(PW)) dut (
    .clk        (clk),
    .reset      (reset),
    .if_pc      (if_pc),
    .imem_instr (imem_instr),
    .flush      (flush),
    .id_ready   (id_ready),
    .id_valid   (id_valid),
    .id_pc      (id_pc),
    .id_instr   (id_instr),
    .stall      (stall),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [IW-1:0] instr_of(input logic [PW-1:0] pc);
    return (pc * 32'h9E37_79B1) ^ 32'hA5A5_0001;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_reset_values();
    chk("rst_valid", 64'(id_valid), 64'd0);
    chk("rst_pc",    64'(id_pc),    64'd0);
    chk("rst_instr", 64'(id_instr), 64'd0);
    chk("rst_count", 64'(count),    64'd0);
    chk("rst_stall", 64'(stall),    64'd0);
  endtask

  // One cycle: drive inputs, check model predictions, clock, update model and IF.
  task automatic step(input bit fl, input bit rdy, input logic [PW-1:0] tgt);
    bit            e_valid;
    bit            e_stall;
    logic [PW-1:0] e_pc;
    logic [IW-1:0] e_in;
    if_pc      = pc_m;
    imem_instr = instr_of(pc_m);
    flush      = fl;
    id_ready   = rdy;
    #1;
    e_valid = (mq_pc.size() > 0);
    e_pc    = e_valid ? mq_pc[0] : '0;
    e_in    = e_valid ? mq_in[0] : '0;
    e_stall = !fl && (mq_pc.size() == DEPTH) && !(e_valid && rdy);
    chk("valid", 64'(id_valid), 64'(e_valid));
    chk("pc",    64'(id_pc),    64'(e_pc));
    chk("instr", 64'(id_instr), 64'(e_in));
    chk("stall", 64'(stall),    64'(e_stall));
    chk("count", 64'(count),    64'(mq_pc.size()));
    @(posedge clk);
    if (e_valid && rdy) begin
      void'(mq_pc.pop_front());
      void'(mq_in.pop_front());
    end
    if (fl) begin
      mq_pc.delete();
      mq_in.delete();
    end else if (mq_pc.size() < DEPTH) begin
      mq_pc.push_back(pc_m);
      mq_in.push_back(instr_of(pc_m));
    end
    if (fl)            pc_m = tgt;
    else if (!e_stall) pc_m = pc_m + 1;
    @(negedge clk);
  endtask

  // Asynchronous reset between edges: outputs must clear immediately.
  task automatic reset_pulse();
    #2 reset = 1'b0;
    #1 chk_reset_values();
    mq_pc.delete();
    mq_in.delete();
    pc_m = '0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; if_pc = '0; imem_instr = '0; flush = 1'b0; id_ready = 1'b0;
    pc_m = '0;
    #3 chk_reset_values();
    @(negedge clk);
    reset = 1'b1;

    // Three captures with ID not ready, then asynchronous reset.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0);
    #1;
    chk("t1_count", 64'(count), 64'd3);
    chk("t1_pc",    64'(id_pc), 64'd0);
    chk("t1_stall", 64'(stall), 64'd0);
    reset_pulse();

    // Fill with PCs 0..3, PC 4 offered and stalled, then pop/push same edge.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, '0);
    #1;
    chk("t2_count", 64'(count), 64'd4);
    chk("t2_head",  64'(id_pc), 64'd1);

    // Flush while full with wrong-path PC 7 on the bus.
    pc_m = 7;
    step(1'b1, 1'b0, 32'd0);
    #1;
    chk("t3_count", 64'(count),    64'd0);
    chk("t3_valid", 64'(id_valid), 64'd0);
    chk("t3_instr", 64'(id_instr), 64'd0);

    // Streaming from an empty queue with ID always ready, across the wrap.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, '0);
    #1;
    chk("t4_count", 64'(count), 64'd1);
    chk("t4_head",  64'(id_pc), 64'd9);

    // Flush coincident with the pop of PC 5; next entry is the target.
    step(1'b1, 1'b1, 32'd5);
    step(1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 32'd40);
    step(1'b0, 1'b0, '0);
    #1;
    chk("t6_head",  64'(id_pc), 64'd40);
    chk("t6_count", 64'(count), 64'd1);

    // Randomized traffic with back-pressure, flushes and one async reset.
    for (int i = 0; i < 600; i++) begin
      bit fl;
      bit rdy;
      fl  = ($urandom_range(0, 11) == 0);
      rdy = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      step(fl, rdy, 32'($urandom_range(0, 4095)));
      if (i == 350) reset_pulse();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
